inst_fetch: RTL

Instruction fetch stage directly downstream of the PC register. Takes the current `pc`/`ce`, reads the 32-bit instruction as four byte reads from the byte-wide memory arbiter, and presents `{pc, inst}` to the decode stage through its own output register, which serves as the IF/ID register. Holds the PC via `stallreq_if` while a fetch is in progress. Aborts on a branch redirect.

---
 rtl/inst_fetch.sv | 93 +++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: byte-serial instruction fetch with IF/ID output register, stall hold and branch abort
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ce,
  input  logic [5:0]  stall,
  input  logic        br,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        stallreq_if,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t      r_state, w_state;
  logic [1:0]  r_cnt, w_cnt;
  logic [23:0] r_part, w_part;
  logic [31:0] r_hpc, r_hinst, w_hpc, w_hinst, w_pc, w_inst;
  logic        w_valid, w_fetch, w_done;
  logic        w_unused;
  assign w_unused = &{1'b0, stall[5:2], stall[0]};
  assign w_fetch = ce & ~br & (r_state == FETCH);
  assign w_done = w_fetch & mem_ack & (r_cnt == 2'd3);
  assign mem_req = w_fetch;
  assign mem_addr = pc + {30'd0, r_cnt};
  assign stallreq_if = w_fetch & ~w_done;
  // bytes 0..2 shift in from the top so the partial buffer ends up little-endian
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_part = r_part;
    w_hpc = r_hpc;
    w_hinst = r_hinst;
    w_pc = if_pc;
    w_inst = if_inst;
    w_valid = if_valid;
    if (!ce || br) begin
      w_state = FETCH;
      w_cnt = 2'd0;
      if (!ce || !stall[1]) {w_pc, w_inst, w_valid} = '0;
    end else if (r_state == HOLD) begin
      if (!stall[1]) begin
        w_state = FETCH;
        w_cnt = 2'd0;
        w_pc = r_hpc;
        w_inst = r_hinst;
        w_valid = 1'b1;
      end
    end else if (w_done) begin
      w_cnt = 2'd0;
      if (stall[1]) begin
        w_state = HOLD;
        w_hpc = pc;
        w_hinst = {mem_rdata, r_part};
      end else begin
        w_pc = pc;
        w_inst = {mem_rdata, r_part};
        w_valid = 1'b1;
      end
    end else begin
      if (mem_ack) begin
        w_part = {mem_rdata, r_part[23:8]};
        w_cnt = r_cnt + 2'd1;
      end
      if (!stall[1]) {w_pc, w_inst, w_valid} = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_cnt <= 2'd0;
      r_part <= '0;
      r_hpc <= '0;
      r_hinst <= '0;
      if_pc <= '0;
      if_inst <= '0;
      if_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_part <= w_part;
      r_hpc <= w_hpc;
      r_hinst <= w_hinst;
      if_pc <= w_pc;
      if_inst <= w_inst;
      if_valid <= w_valid;
    end
  end
endmodule
